fsm_input_conditioner: RTL and testbench

Front-end conditioner between the board pushbutton/slide switches and the sequence state machine. Synchronizes and debounces KEY0 and SW[4:0]. Emits a single-cycle `step` strobe per debounced press, with a switch command word latched on that same edge. The state machine can therefore advance on `step` in the system clock domain instead of clocking directly off a raw button.

---
 rtl/fsm_input_conditioner.sv | 172 +++++++++++++++++
 tb/tb_fsm_input_conditioner.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_input_conditioner.sv
// Synchronizes and debounces KEY0/SW[4:0] and emits one step strobe per press.
// Define FSM_INPUT_AUTOREPEAT_EN to add timed auto-repeat steps while KEY0 is held.
module fsm_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic       CLOCK_50,
    input  logic       KEY1,
    input  logic       KEY0,
    input  logic [4:0] SW,
    output logic       step,
    output logic [4:0] sw_cmd,
    output logic [4:0] sw_live,
    output logic       key_held,
    output logic [7:0] press_cnt
);

    localparam int NIN = 6;
    localparam int CW  = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    // Bit 5 is the key (idle high); bits 4:0 are the switches (idle low).
    localparam logic [NIN-1:0] RST_LVL = 6'b100000;

`ifdef FSM_INPUT_AUTOREPEAT_EN
    localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                         : REPEAT_PERIOD;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] DLY_LAST = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] PER_LAST = TW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE,
        HELD,
        REPEAT
    } state_e;

    logic [TW-1:0] tmr_q, tmr_d;
`else
    typedef enum logic [0:0] {
        IDLE,
        HELD
    } state_e;
`endif

    logic [NIN-1:0] raw;
    logic [NIN-1:0] s1_q, s2_q;
    logic [NIN-1:0] deb_q, deb_d;
    logic [CW-1:0]  cnt_q [NIN];
    logic [CW-1:0]  cnt_d [NIN];

    state_e     state_q, state_d;
    logic       step_q, step_d;
    logic [4:0] sw_cmd_q, sw_cmd_d;
    logic [7:0] press_q, press_d;
    logic       deb_key;

    assign raw = {KEY0, SW};

    always_ff @(posedge CLOCK_50 or negedge KEY1) begin
        if (!KEY1) begin
            s1_q  <= RST_LVL;
            s2_q  <= RST_LVL;
            deb_q <= RST_LVL;
            for (int i = 0; i < NIN; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q  <= raw;
            s2_q  <= s1_q;
            deb_q <= deb_d;
            for (int i = 0; i < NIN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Counter only advances while the synced input disagrees with the
    // debounced level; any agreement restarts the stability window.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < NIN; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                deb_d[i] = s2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    assign deb_key  = deb_q[5];
    assign sw_live  = deb_q[4:0];
    assign key_held = ~deb_key;

    always_ff @(posedge CLOCK_50 or negedge KEY1) begin
        if (!KEY1) begin
            state_q  <= IDLE;
            step_q   <= 1'b0;
            sw_cmd_q <= '0;
            press_q  <= '0;
`ifdef FSM_INPUT_AUTOREPEAT_EN
            tmr_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            sw_cmd_q <= sw_cmd_d;
            press_q  <= press_d;
`ifdef FSM_INPUT_AUTOREPEAT_EN
            tmr_q    <= tmr_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        step_d   = 1'b0;
        sw_cmd_d = sw_cmd_q;
        press_d  = press_q;
`ifdef FSM_INPUT_AUTOREPEAT_EN
        tmr_d    = '0;
`endif
        unique case (state_q)
            IDLE: begin
                if (!deb_key) begin
                    step_d  = 1'b1;
                    state_d = HELD;
                end
            end
            HELD: begin
                if (deb_key) begin
                    state_d = IDLE;
`ifdef FSM_INPUT_AUTOREPEAT_EN
                end else if (tmr_q == DLY_LAST) begin
                    step_d  = 1'b1;
                    state_d = REPEAT;
                end else begin
                    tmr_d = tmr_q + 1'b1;
`endif
                end
            end
`ifdef FSM_INPUT_AUTOREPEAT_EN
            REPEAT: begin
                if (deb_key) begin
                    state_d = IDLE;
                end else if (tmr_q == PER_LAST) begin
                    step_d = 1'b1;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
        // Latch the pre-edge debounced switches, even if one flips this edge.
        if (step_d) begin
            sw_cmd_d = sw_live;
            press_d  = press_q + 8'd1;
        end
    end

    assign step      = step_q;
    assign sw_cmd    = sw_cmd_q;
    assign press_cnt = press_q;

endmodule

// File: tb/tb_fsm_input_conditioner.sv
// Randomized scoreboard bench for fsm_input_conditioner against a
// history-based reference model of debounce, press and repeat timing.
module tb_fsm_input_conditioner;

    localparam int D      = 4;
    localparam int RDELAY = 20;
    localparam int RPER   = 8;
`ifdef FSM_INPUT_AUTOREPEAT_EN
    localparam bit AUTOREP = 1'b1;
`else
    localparam bit AUTOREP = 1'b0;
`endif
    localparam logic [5:0] RST = 6'b100000;

    typedef struct packed {
        logic [4:0] cmd;
        logic [7:0] cnt;
    } exp_t;

    logic       clk;
    logic       KEY1;
    logic       KEY0;
    logic [4:0] SW;
    logic       step;
    logic [4:0] sw_cmd;
    logic [4:0] sw_live;
    logic       key_held;
    logic [7:0] press_cnt;

    int checks = 0;
    int errors = 0;

    exp_t       sb[$];
    logic [5:0] hist[$];
    logic [5:0] m_deb     = RST;
    bit         m_pressed = 1'b0;
    int         m_next    = 0;
    logic [7:0] m_cnt     = '0;
    logic [4:0] m_cmd     = '0;
    int         edge_n    = 0;

    fsm_input_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY(RDELAY),
        .REPEAT_PERIOD(RPER)
    ) dut (
        .CLOCK_50(clk),
        .KEY1(KEY1),
        .KEY0(KEY0),
        .SW(SW),
        .step(step),
        .sw_cmd(sw_cmd),
        .sw_live(sw_live),
        .key_held(key_held),
        .press_cnt(press_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s edge %0d: got %0h want %0h",
                     nm, edge_n, act, exp);
        end
    endtask

    // Reference model: a level is accepted once the last D synchronized
    // samples (raw samples delayed two edges) all disagree with it.
    always @(posedge clk) begin
        bit         step_now;
        bit         all_diff;
        logic [5:0] new_deb;
        int         n;
        if (!KEY1) begin
            hist      = '{RST, RST};
            m_deb     = RST;
            m_pressed = 1'b0;
            m_cnt     = '0;
            m_cmd     = '0;
        end else begin
            step_now = 1'b0;
            if (!m_pressed) begin
                if (!m_deb[5]) begin
                    step_now  = 1'b1;
                    m_pressed = 1'b1;
                    m_next    = edge_n + RDELAY;
                end
            end else if (m_deb[5]) begin
                m_pressed = 1'b0;
            end else if (AUTOREP && edge_n == m_next) begin
                step_now = 1'b1;
                m_next   = edge_n + RPER;
            end
            if (step_now) begin
                m_cnt = m_cnt + 8'd1;
                m_cmd = m_deb[4:0];
                sb.push_back('{cmd: m_cmd, cnt: m_cnt});
            end
            hist.push_back({KEY0, SW});
            if (hist.size() > D + 3) void'(hist.pop_front());
            n       = hist.size();
            new_deb = m_deb;
            for (int b = 0; b < 6; b++) begin
                all_diff = (n >= D + 2);
                if (all_diff) begin
                    for (int k = 0; k < D; k++) begin
                        if (hist[n - 3 - k][b] == m_deb[b]) all_diff = 1'b0;
                    end
                end
                if (all_diff) new_deb[b] = ~m_deb[b];
            end
            m_deb = new_deb;
        end
        edge_n++;
    end

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (step === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("step_unexpected", {31'b0, step}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("step_cmd", {27'b0, sw_cmd}, {27'b0, e.cmd});
                    chk("step_cnt", {24'b0, press_cnt}, {24'b0, e.cnt});
                end
            end else if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("step_missing", {31'b0, step}, 32'd1);
            end
            chk("sw_live", {27'b0, sw_live}, {27'b0, m_deb[4:0]});
            chk("key_held", {31'b0, key_held}, {31'b0, !m_deb[5]});
            chk("press_cnt", {24'b0, press_cnt}, {24'b0, m_cnt});
            chk("sw_cmd", {27'b0, sw_cmd}, {27'b0, m_cmd});
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int lo, input int hi);
        KEY0 = 1'b0;
        cyc(lo);
        KEY0 = 1'b1;
        cyc(hi);
    endtask

    initial begin
        logic [7:0] cnt0;
        KEY1 = 1'b0;
        KEY0 = 1'b1;
        SW   = '0;
        cyc(3);
        KEY1 = 1'b1;
        cyc(10);

        // Clean presses with varying switch words
        SW = 5'b10101;
        cyc(8);
        press(15, 12);
        SW = 5'b01110;
        cyc(8);
        press(10, 12);
        SW = 5'b11001;
        cyc(8);
        press(9, 12);

        // Asynchronous reset mid-run
        chk("pre_rst_cnt", {24'b0, press_cnt}, 32'd3);
        KEY1 = 1'b0;
        #1;
        chk("rst_async", {19'b0, step, sw_cmd, sw_live, key_held, press_cnt},
            32'd0);
        SW = '0;
        cyc(3);
        KEY1 = 1'b1;
        cyc(10);

        // Bounce: low 3 / high 2, never stable long enough
        for (int i = 0; i < 8; i++) begin
            KEY0 = 1'b0;
            cyc(3);
            KEY0 = 1'b1;
            cyc(2);
        end
        cyc(10);
        chk("bounce_cnt", {24'b0, press_cnt}, 32'd0);

        // Long hold with a switch change mid-hold
        SW = 5'b01000;
        cyc(8);
        KEY0 = 1'b0;
        cyc(100);
        SW = 5'b00011;
        cyc(100);
        KEY0 = 1'b1;
        cyc(12);

        // 60-cycle hold (repeat timing in the repeat build)
        press(60, 15);

        // Switch accepted on the same edge that raises step
        SW = 5'b00110;
        cyc(8);
        KEY0 = 1'b0;
        cyc(1);
        SW = 5'b11100;
        cyc(14);
        KEY0 = 1'b1;
        cyc(12);

        // Key held across reset release
        KEY0 = 1'b0;
        cyc(3);
        KEY1 = 1'b0;
        cyc(3);
        KEY1 = 1'b1;
        cyc(20);
        KEY0 = 1'b1;
        cyc(12);

        // Randomized key/switch activity
        for (int i = 0; i < 300; i++) begin
            KEY0 = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) SW = 5'($urandom);
            cyc($urandom_range(1, 9));
        end
        KEY0 = 1'b1;
        cyc(15);

        // 256 presses wrap the counter back to where it started
        cnt0 = m_cnt;
        for (int i = 0; i < 256; i++) begin
            press(8, 8);
        end
        cyc(10);
        chk("wrap_cnt", {24'b0, press_cnt}, {24'b0, cnt0});

        cyc(20);
        chk("sb_drain", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
